rx_4phase_fifo: RTL
===================

Name: rx_4phase_fifo

Overview:
Parametrised successor to the two-flop 4-phase handshake receiver in the clk_rx domain. It synchronises the incoming req through a configurable number of flops and captures the bundled data into a small first-word-fall-through FIFO. It completes the 4-phase ack handshake and presents the data on a valid/ready interface. When the FIFO is full, it withholds ack so the sender is back-pressured.

Parameters:
DATA_W, 8, width of data and rdata
SYNC_STAGES, 2, number of req synchroniser flops (min 2)
FIFO_DEPTH, 4, FIFO entries; power of two, min 2
ADDR_W, log2(FIFO_DEPTH), derived pointer width; not to be overridden

Ports:
clk_rx  input  1  receive-domain clock; all state on rising edge
reset  input  1  asynchronous, active-low reset
req  input  1  4-phase request from sender domain (asynchronous to clk_rx)
data  input  DATA_W  bundled data; sender holds it stable from req rise until ack seen high
ack  output  1  4-phase acknowledge to sender; registered
rdata  output  DATA_W  FIFO head word; valid only when vo=1
vo  output  1  FIFO non-empty (head word valid)
rd_ready  input  1  consumer accepts head word when vo=1
fill  output  ADDR_W+1  number of occupied entries, 0..FIFO_DEPTH
stall  output  1  req_s=1 in IDLE with FIFO full (handshake held off)

Behaviour:
- Reset (reset=0, async): sync chain cleared to 0, FSM=IDLE, ack=0, rd/wr pointers=0, fill=0, vo=0, stall=0, rdata=don't-care (storage not reset).
- Synchroniser: req passes through SYNC_STAGES flops; req_s = last stage. No logic between stages.
- FSM, two states:
  - IDLE: if req_s=1 and fill<FIFO_DEPTH, write data into FIFO, ack<=1, go to WAIT_LOW. If req_s=1 and full, stay in IDLE with ack=0 and stall=1.
  - WAIT_LOW: ack held 1. When req_s=0, ack<=0 and go to IDLE.
- Data is sampled only on the write edge; it is never re-sampled during WAIT_LOW.
- Latency: req rises before edge 1 -> req_s=1 after edge SYNC_STAGES -> write, ack=1 and vo=1 after edge SYNC_STAGES+1 (FIFO initially empty). ack falls SYNC_STAGES+1 edges after req falls.
- One word per full 4-phase cycle. A req that falls and rises again within the sync window must still yield exactly one word per ack cycle.
- FIFO (FWFT):
  - vo = (fill!=0); rdata = mem[rd_ptr].
  - Pop on vo & rd_ready.
  - Push and pop on the same edge: both occur and fill is unchanged. Allowed whenever fill<FIFO_DEPTH at push time.
  - Full is evaluated before the same-cycle pop, so a push on a full FIFO is deferred one cycle even if a pop occurs.
  - Pointers wrap modulo FIFO_DEPTH. fill is the registered occupancy.
  - Overflow is impossible by construction. A pop with vo=0 is ignored.
- stall is combinational: (state==IDLE) & req_s & full. It clears on the edge a pop frees an entry; the deferred push happens on the following edge.
- Reset mid-handshake: all state clears and buffered words are lost. If req is still 1 after reset release, it is treated as a new transfer. The sender is required to be reset together with this block.
- ack, vo and fill change only on clk_rx edges or on async reset.

Decomposition:
- Shared package rx_pkg: default DATA_W, SYNC_STAGES, FIFO_DEPTH; FSM state encoding (IDLE=1'b0, WAIT_LOW=1'b1); clog2 helper function.
- One sub-module, sync_chain: parametrised SYNC_STAGES-deep single-bit synchroniser with async active-low reset. Reused for other CDC inputs.
- FIFO storage, pointers and FSM stay inline in rx_4phase_fifo.

Test Plan:
- Reset then single transfer with SYNC_STAGES=2: data=8'hA5, raise req -> ack=1 and vo=1 with rdata=8'hA5 after 3rd edge. Drop req -> ack=0 after 3 edges. fill=1 until rd_ready pulse, then 0.
- Fill to full with rd_ready=0: 4 transfers (8'h01..8'h04) -> fill=4. 5th req (8'h05) -> stall=1, ack stays 0. One pop -> stall clears, ack rises next edge, fill=4. Read-out order is 01,02,03,04,05.
- Simultaneous push/pop: fill=2 with rd_ready=1 held during a write edge -> fill stays 2, head advances, no word lost or duplicated over 16 random transfers.
- Pointer wrap: 10 transfers with continuous rd_ready=1 at FIFO_DEPTH=4 -> all 10 words (8'h10..8'h19) emerge in order and fill never exceeds 1.
- Reset mid-handshake: assert reset while state=WAIT_LOW with fill=2 -> immediately ack=0, vo=0, fill=0. Release with req=1 -> one new word captured and ack rises after SYNC_STAGES+1 edges.
- Parameter sweep SYNC_STAGES=3, DATA_W=16, FIFO_DEPTH=8: data=16'hBEEF -> ack and vo after 4th edge; 8 transfers with no reads give fill=8 and stall on the 9th.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared definitions for the 4-phase receive FIFO and its helpers.
//   - default parameter values for DATA_W, SYNC_STAGES and FIFO_DEPTH
//   - handshake FSM state encoding
//   - clog2 helper used to size FIFO pointers
package rx_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FIFO_DEPTH_DEF  = 4;

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_LOW = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rx_4phase_fifo_if.sv
// Bus bundle for rx_4phase_fifo.
//   Sender side  : req, data (into the receiver), ack (back to the sender)
//   Consumer side: rdata, vo (head word valid), rd_ready (consumer accepts)
//   Status       : fill (occupied entries), stall (handshake held off, FIFO full)
// The slave modport is the receiver's view; the master modport is the
// sender/consumer view.
interface rx_4phase_fifo_if #(
    parameter int DATA_W     = rx_pkg::DATA_W_DEF,
    parameter int FIFO_DEPTH = rx_pkg::FIFO_DEPTH_DEF
);
    import rx_pkg::*;

    localparam int ADDR_W = clog2(FIFO_DEPTH);

    logic              req;
    logic [DATA_W-1:0] data;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              vo;
    logic              rd_ready;
    logic [ADDR_W:0]   fill;
    logic              stall;

    modport master (
        output req, data, rd_ready,
        input  ack, rdata, vo, fill, stall
    );

    modport slave (
        input  req, data, rd_ready,
        output ack, rdata, vo, fill, stall
    );

endinterface

// File: rtl/sync_chain.sv
// Single-bit multi-flop synchroniser for asynchronous inputs.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage to 0
//   d     : asynchronous input
//   q     : synchronised output (last stage)
// The stages are a pure shift register; nothing may be inserted between them.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rx_4phase_fifo.sv
// 4-phase handshake receiver feeding a first-word-fall-through FIFO.
//   clk_rx : receive-domain clock, all state on the rising edge
//   reset  : asynchronous active-low reset (FIFO storage is not cleared)
//   bus    : slave view of rx_4phase_fifo_if
//            req/data/ack  - 4-phase sender handshake, ack registered
//            rdata/vo      - FIFO head word and its valid flag
//            rd_ready      - consumer pops the head when vo=1
//            fill          - registered occupancy, 0..FIFO_DEPTH
//            stall         - synchronised req seen in IDLE while FIFO full
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for req_s=1 with room in the FIFO; capture then ack
// WAIT_LOW | word captured, ack held high until req_s returns to 0
module rx_4phase_fifo #(
    parameter int DATA_W      = rx_pkg::DATA_W_DEF,
    parameter int SYNC_STAGES = rx_pkg::SYNC_STAGES_DEF,
    parameter int FIFO_DEPTH  = rx_pkg::FIFO_DEPTH_DEF
) (
    input  logic            clk_rx,
    input  logic            reset,
    rx_4phase_fifo_if.slave bus
);
    import rx_pkg::*;

    localparam int ADDR_W = clog2(FIFO_DEPTH);

    localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W:0]   FILL_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    logic              req_s;

    logic [0:0]        state_q, state_d;
    logic              ack_q, ack_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   fill_q, fill_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

    logic              full;
    logic              not_empty;
    logic              push;
    logic              pop;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk_rx),
        .rst_n (reset),
        .d     (bus.req),
        .q     (req_s)
    );

    // Full is judged on the registered count, so a pop on the same edge
    // does not let a push through; the push waits one more cycle.
    assign full      = (fill_q == FULL_CNT);
    assign not_empty = (fill_q != '0);
    assign push      = (state_q == ST_IDLE) && req_s && !full;
    assign pop       = not_empty && bus.rd_ready;

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        if (state_q == ST_IDLE) begin
            if (push) begin
                state_d = ST_WAIT_LOW;
                ack_d   = 1'b1;
            end
        end else begin
            if (!req_s) begin
                state_d = ST_IDLE;
                ack_d   = 1'b0;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            fill_d = fill_q + FILL_ONE;
        end else if (!push && pop) begin
            fill_d = fill_q - FILL_ONE;
        end
    end

    always_ff @(posedge clk_rx or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Data is bundled with req: it is only sampled on the capture edge.
    always_ff @(posedge clk_rx) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.data;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.rdata = mem_q[rd_ptr_q];
    assign bus.vo    = not_empty;
    assign bus.fill  = fill_q;
    assign bus.stall = (state_q == ST_IDLE) && req_s && full;

endmodule
